// File: rtl/rsa_run_controller.sv
// Run sequencer: hold the CPU in reset until a start edge, run to EndFlag (or watchdog),
// drain the pipeline, then stream a window of data memory byte-by-byte to the UART TX.
// Latency: FETCH/WAIT/SEND per byte (>= 3 cycles/byte); SEND holds tx_valid/tx_data until tx_ready.
module rsa_run_controller #(
  parameter int ADDR_W       = 10,
  parameter int DUMP_BASE    = 0,
  parameter int DUMP_LEN     = 256,
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 2**20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              end_flag,
  output logic              cpu_rst,
  output logic              cpu_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              com_flag,
  output logic [7:0]        serial_ctr,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_DRAIN, S_FETCH, S_WAIT, S_SEND, S_DONE
  } state_t;

  localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0]       DRAIN_LOAD   = 32'(DRAIN_CYCLES);
  localparam logic [31:0]       LAST_IDX     = 32'(DUMP_LEN - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(DUMP_BASE);
  // With nothing to dump the drain goes straight to DONE.
  localparam state_t            POST_DRAIN   = (DUMP_LEN == 0) ? S_DONE : S_FETCH;

  state_t      state_q, state_d;
  logic        start_prev_q, start_prev_d;
  logic [31:0] run_ctr_q, run_ctr_d;
  logic [31:0] drain_ctr_q, drain_ctr_d;
  logic [31:0] idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [7:0]  serial_ctr_q, serial_ctr_d;
  logic        timeout_q, timeout_d;
  logic        start_rise;

  assign start_rise = start && !start_prev_q;

  // State register; the edge detector resets high so a start held through reset is not an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      start_prev_q <= 1'b1;
      run_ctr_q    <= '0;
      drain_ctr_q  <= '0;
      idx_q        <= '0;
      tx_data_q    <= '0;
      serial_ctr_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      run_ctr_q    <= run_ctr_d;
      drain_ctr_q  <= drain_ctr_d;
      idx_q        <= idx_d;
      tx_data_q    <= tx_data_d;
      serial_ctr_q <= serial_ctr_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state and datapath updates; end_flag takes priority over the watchdog terminal count.
  always_comb begin
    state_d      = state_q;
    start_prev_d = start;
    run_ctr_d    = run_ctr_q;
    drain_ctr_d  = drain_ctr_q;
    idx_d        = idx_q;
    tx_data_d    = tx_data_q;
    serial_ctr_d = serial_ctr_q;
    timeout_d    = timeout_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          state_d      = S_RUN;
          run_ctr_d    = '0;
          idx_d        = '0;
          serial_ctr_d = '0;
          timeout_d    = 1'b0;
        end
      end
      S_RUN: begin
        run_ctr_d = run_ctr_q + 32'd1;
        if (end_flag || (TIMEOUT != 0 && run_ctr_q == TIMEOUT_LAST)) begin
          drain_ctr_d = DRAIN_LOAD;
          state_d     = (DRAIN_CYCLES == 0) ? POST_DRAIN : S_DRAIN;
          if (!end_flag) timeout_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_ctr_q <= 32'd1) state_d = POST_DRAIN;
        else drain_ctr_d = drain_ctr_q - 32'd1;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        tx_data_d = mem_rdata;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          serial_ctr_d = serial_ctr_q + 8'd1;
          idx_d        = idx_q + 32'd1;
          state_d      = (idx_q == LAST_IDX) ? S_DONE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode directly from the state so an async reset clears them in the same cycle.
  always_comb begin
    cpu_rst    = (state_q == S_IDLE) || (state_q == S_DONE);
    cpu_en     = (state_q == S_RUN) || (state_q == S_DRAIN);
    com_flag   = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_SEND);
    tx_valid   = (state_q == S_SEND);
    busy       = !cpu_rst;
    done       = (state_q == S_DONE);
    mem_addr   = BASE_ADDR + idx_q[ADDR_W-1:0];
    tx_data    = tx_data_q;
    serial_ctr = serial_ctr_q;
    timeout    = timeout_q;
  end

endmodule
